// File: rtl/regfile_w2r2.sv
// Y86-64 register file: 15 x DATA_W registers, two decode read ports, one debug read port, two write-back write ports, and a saturating count of committed writes.
// Latency: reads are combinational (0 cycles, pre-edge contents); writes take effect at the rising edge.
// Backpressure: none; every qualified write is accepted on the edge, and W_en_i=0 leaves all state untouched.
module regfile_w2r2 #(
   parameter int                DATA_W    = 64,
   parameter logic [DATA_W-1:0] RSP_RESET = '0,
   parameter int                CNT_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [3:0]        d_srcA_i,
   input  logic [3:0]        d_srcB_i,
   output logic [DATA_W-1:0] d_rvalA_o,
   output logic [DATA_W-1:0] d_rvalB_o,
   input  logic              W_en_i,
   input  logic [3:0]        W_dstE_i,
   input  logic [DATA_W-1:0] W_valE_i,
   input  logic [3:0]        W_dstM_i,
   input  logic [DATA_W-1:0] W_valM_i,
   input  logic [3:0]        dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o,
   output logic [CNT_W-1:0]  wr_cnt_o
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam int         RSP   = 4;

   logic [DATA_W-1:0] regs_q [15];
   logic [DATA_W-1:0] regs_d [15];
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

   logic              e_wr;
   logic              m_wr;
   logic              coll;
   logic [1:0]        n_wr;
   logic [CNT_W:0]    cnt_sum;

   // Write qualification: W_en_i gates first, so X on a dst while idle cannot leak into state.
   always_comb begin
      e_wr = W_en_i && (W_dstE_i != RNONE);
      m_wr = W_en_i && (W_dstM_i != RNONE);
      coll = e_wr && m_wr && (W_dstE_i == W_dstM_i);
      if (e_wr && m_wr && !coll) begin
         n_wr = 2'd2;
      end else if (e_wr || m_wr) begin
         n_wr = 2'd1;
      end else begin
         n_wr = 2'd0;
      end
   end

   // Next register contents; the M port is applied last, so it wins when both ports target one register (popq %rsp).
   always_comb begin
      for (int i = 0; i < 15; i++) begin
         regs_d[i] = regs_q[i];
         if (e_wr && (W_dstE_i == 4'(i))) begin
            regs_d[i] = W_valE_i;
         end
         if (m_wr && (W_dstM_i == 4'(i))) begin
            regs_d[i] = W_valM_i;
         end
      end
   end

   // Saturating counter: the extra top bit catches any overflow, including +2 from max-1.
   always_comb begin
      cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(n_wr);
      if (cnt_sum[CNT_W]) begin
         cnt_d = '1;
      end else begin
         cnt_d = cnt_sum[CNT_W-1:0];
      end
   end

   // State registers; asynchronous reset wins over any write pending in the same cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 15; i++) begin
            regs_q[i] <= (i == RSP) ? RSP_RESET : '0;
         end
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < 15; i++) begin
            regs_q[i] <= regs_d[i];
         end
         cnt_q <= cnt_d;
      end
   end

   // Read ports: no bypass from the write ports; RNONE reads as zero.
   always_comb begin
      d_rvalA_o  = (d_srcA_i   == RNONE) ? '0 : regs_q[d_srcA_i];
      d_rvalB_o  = (d_srcB_i   == RNONE) ? '0 : regs_q[d_srcB_i];
      dbg_data_o = (dbg_addr_i == RNONE) ? '0 : regs_q[dbg_addr_i];
      wr_cnt_o   = cnt_q;
   end

endmodule

// File: tb/tb_regfile_w2r2.sv
module tb_regfile_w2r2;

   logic        clk;
   logic        rst_n;
   logic [3:0]  src_a, src_b, dbg_addr;
   logic        w_en;
   logic [3:0]  dst_e, dst_m;
   logic [63:0] val_e, val_m;
   logic [63:0] rval_a, rval_b, dbg_data;
   logic [31:0] cnt_a;
   logic [63:0] rval_a4, rval_b4, dbg_data4;
   logic [3:0]  cnt_b;

   int errors = 0;
   int checks = 0;

   // Reference model: register array plus counters for both counter widths.
   logic [63:0] model [15];
   longint      m_cnt32;
   int          m_cnt4;

   regfile_w2r2 #(.DATA_W(64), .RSP_RESET(64'h200), .CNT_W(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .d_srcA_i(src_a), .d_srcB_i(src_b),
      .d_rvalA_o(rval_a), .d_rvalB_o(rval_b),
      .W_en_i(w_en), .W_dstE_i(dst_e), .W_valE_i(val_e),
      .W_dstM_i(dst_m), .W_valM_i(val_m),
      .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data), .wr_cnt_o(cnt_a)
   );

   regfile_w2r2 #(.DATA_W(64), .RSP_RESET(64'h200), .CNT_W(4)) dut4 (
      .clk_i(clk), .rst_n_i(rst_n),
      .d_srcA_i(src_a), .d_srcB_i(src_b),
      .d_rvalA_o(rval_a4), .d_rvalB_o(rval_b4),
      .W_en_i(w_en), .W_dstE_i(dst_e), .W_valE_i(val_e),
      .W_dstM_i(dst_m), .W_valM_i(val_m),
      .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data4), .wr_cnt_o(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] m_rd(input logic [3:0] a);
      return (a == 4'hF) ? 64'h0 : model[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 15; i++) model[i] = (i == 4) ? 64'h200 : 64'h0;
      m_cnt32 = 0;
      m_cnt4  = 0;
   endtask

   // Advance one edge and apply the architectural write rules to the model.
   task automatic commit();
      int n;
      @(posedge clk);
      if (rst_n && w_en) begin
         n = 0;
         if (dst_e != 4'hF) model[dst_e] = val_e;
         if (dst_m != 4'hF) model[dst_m] = val_m;
         if (dst_e != 4'hF) n++;
         if (dst_m != 4'hF && dst_m != dst_e) n++;
         m_cnt32 = m_cnt32 + n;
         if (m_cnt32 > 64'hFFFF_FFFF) m_cnt32 = 64'hFFFF_FFFF;
         m_cnt4 = m_cnt4 + n;
         if (m_cnt4 > 15) m_cnt4 = 15;
      end
      #1;
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < 15; i++) begin
         dbg_addr = 4'(i);
         #1;
         chk($sformatf("%s_dbg%0d", tag, i), dbg_data, m_rd(4'(i)));
      end
   endtask

   task automatic dual_write(input logic [3:0] e, input logic [3:0] m);
      w_en = 1'b1; dst_e = e; dst_m = m;
      val_e = {$urandom, $urandom}; val_m = {$urandom, $urandom};
      commit();
      w_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; w_en = 1'b0;
      src_a = 4'h0; src_b = 4'h0; dbg_addr = 4'h0;
      dst_e = 4'hF; dst_m = 4'hF; val_e = '0; val_m = '0;
      model_reset();
      #3;

      // Reset contents.
      for (int i = 0; i < 15; i++) begin
         dbg_addr = 4'(i);
         #1;
         chk($sformatf("rst_dbg%0d", i), dbg_data, (i == 4) ? 64'h200 : 64'h0);
      end
      src_a = 4'hF; dbg_addr = 4'hF;
      #1;
      chk("rst_rnone_a", rval_a, 64'h0);
      chk("rst_rnone_dbg", dbg_data, 64'h0);
      chk("rst_cnt", {32'h0, cnt_a}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Dual write to different registers.
      w_en = 1'b1; dst_e = 4'h2; val_e = 64'h11; dst_m = 4'h3; val_m = 64'h22;
      commit();
      w_en = 1'b0; src_a = 4'h2; src_b = 4'h3;
      #1;
      chk("dual_a", rval_a, 64'h11);
      chk("dual_b", rval_b, 64'h22);
      chk("dual_cnt", {32'h0, cnt_a}, 64'd2);

      // Collision on %rsp: M wins, counts once.
      w_en = 1'b1; dst_e = 4'h4; val_e = 64'hAA; dst_m = 4'h4; val_m = 64'hBB;
      commit();
      w_en = 1'b0; src_a = 4'h4;
      #1;
      chk("coll_rsp", rval_a, 64'hBB);
      chk("coll_cnt", {32'h0, cnt_a}, 64'd3);

      // No internal bypass.
      w_en = 1'b1; dst_e = 4'h1; val_e = 64'h55; dst_m = 4'hF; src_b = 4'h1;
      #1;
      chk("nobyp_pre", rval_b, 64'h0);
      commit();
      w_en = 1'b0;
      #1;
      chk("nobyp_post", rval_b, 64'h55);
      chk("nobyp_cnt", {32'h0, cnt_a}, 64'd4);

      // Gating: disabled write, RNONE writes, X dst while disabled.
      w_en = 1'b0; dst_e = 4'h5; val_e = 64'hFF; dst_m = 4'h5; val_m = 64'hFF;
      commit();
      dbg_addr = 4'h5;
      #1;
      chk("gate_en0_reg5", dbg_data, 64'h0);
      chk("gate_en0_cnt", {32'h0, cnt_a}, 64'd4);
      w_en = 1'b1; dst_e = 4'hF; dst_m = 4'hF;
      commit();
      w_en = 1'b0;
      chk("gate_rnone_cnt", {32'h0, cnt_a}, 64'd4);
      dst_e = 4'bxxxx; dst_m = 4'bxxxx;
      commit();
      dst_e = 4'hF; dst_m = 4'hF;
      chk("gate_x_cnt", {32'h0, cnt_a}, 64'd4);
      check_all_regs("gate_x");

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         w_en  = ($urandom_range(0, 3) != 0);
         dst_e = 4'($urandom_range(0, 15));
         dst_m = ($urandom_range(0, 3) == 0) ? dst_e : 4'($urandom_range(0, 15));
         val_e = {$urandom, $urandom};
         val_m = {$urandom, $urandom};
         src_a = 4'($urandom_range(0, 15));
         src_b = ($urandom_range(0, 1) == 0) ? dst_e : 4'($urandom_range(0, 15));
         dbg_addr = 4'($urandom_range(0, 15));
         #1;
         chk("rnd_a", rval_a, m_rd(src_a));
         chk("rnd_b", rval_b, m_rd(src_b));
         chk("rnd_dbg", dbg_data, m_rd(dbg_addr));
         chk("rnd_cnt", {32'h0, cnt_a}, m_cnt32);
         chk("rnd_cnt4", {60'h0, cnt_b}, 64'(m_cnt4));
         commit();
      end
      w_en = 1'b0;
      check_all_regs("rnd_end");

      // Asynchronous reset between edges with a write pending.
      w_en = 1'b1; dst_e = 4'h6; val_e = 64'h99; dst_m = 4'h4; val_m = 64'h98;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all_regs("midrst");
      chk("midrst_cnt", {32'h0, cnt_a}, 64'h0);
      chk("midrst_cnt4", {60'h0, cnt_b}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      w_en = 1'b1; dst_e = 4'h6; val_e = 64'h77; dst_m = 4'hF;
      commit();
      w_en = 1'b0; dbg_addr = 4'h6;
      #1;
      chk("post_rst_write", dbg_data, 64'h77);
      chk("post_rst_cnt", {32'h0, cnt_a}, 64'd1);

      // Saturation of the 4-bit counter.
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 7; k++) dual_write(4'(k), 4'(k + 7));
      chk("sat_pre14", {60'h0, cnt_b}, 64'd14);
      chk("sat_pre14_cnt32", {32'h0, cnt_a}, 64'd14);
      dual_write(4'h0, 4'h1);
      chk("sat_plus2", {60'h0, cnt_b}, 64'd15);
      dual_write(4'h2, 4'h3);
      chk("sat_hold2", {60'h0, cnt_b}, 64'd15);
      dual_write(4'h5, 4'hF);
      chk("sat_hold1", {60'h0, cnt_b}, 64'd15);
      chk("sat_cnt32", {32'h0, cnt_a}, 64'd19);
      check_all_regs("sat_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
